// File: rtl/mips_pkg.sv
// Shared core package: instruction-fill FSM state encoding, word/byte-offset
// width constants, and the PC field-extract helpers used by fetch and the
// instruction cache.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } fillState_e;

  // Width of one instruction word / fill beat, and the byte offset inside it.
  localparam int WORD_W     = 32;
  localparam int BYTE_OFF_W = 2;

  // Generic field extract; callers size-cast the result to the field width.
  function automatic logic [31:0] pcField(input logic [31:0] pc, input int lsb, input int width);
    logic [31:0] mask;
    mask = (width >= 32) ? '1 : ((32'h1 << width) - 32'h1);
    return (pc >> lsb) & mask;
  endfunction

  // Word offset inside a cache line.
  function automatic logic [31:0] pcWord(input logic [31:0] pc, input int offW);
    return pcField(pc, BYTE_OFF_W, offW);
  endfunction

  // Cache line index.
  function automatic logic [31:0] pcIdx(input logic [31:0] pc, input int offW, input int idxW);
    return pcField(pc, BYTE_OFF_W + offW, idxW);
  endfunction

  // Tag above the index field.
  function automatic logic [31:0] pcTag(input logic [31:0] pc, input int offW, input int idxW);
    return pcField(pc, BYTE_OFF_W + offW + idxW, WORD_W - BYTE_OFF_W - offW - idxW);
  endfunction

endpackage

// File: rtl/dff.sv
// Core library register: synchronous active-high reset to zero, load enable.
// Ports:
//   clk   - clock
//   reset - synchronous reset, clears q
//   en    - load enable
//   d     - next value
//   q     - registered value
module dff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/icache_fill_fsm.sv
// Line-refill controller for the instruction cache. Owns the refill state,
// the fill beat counter, the drop flag (line invalidated by a flush while
// its burst was in flight) and the external line request.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   missReq           - lookup missed while IDLE; start a refill
//   missLine          - PC[31:OFF_W+2] of the missing line
//   flush             - cache flush pulse
//   MemAck_FL0        - line request accepted
//   MemDataVal_FL0    - fill beat valid
//   state             - current refill state
//   beatCnt           - word slot for the current fill beat
//   beatWr            - write the current beat into the data array
//   lineDone          - last beat of the line accepted this cycle
//   dropLine          - line must not be marked valid on completion
//   fillLine          - latched line address being refilled
//   MemReq_FL0        - line request, held until acknowledged
//   MemAddr_FL0       - line-aligned request address
module icache_fill_fsm
  import mips_pkg::*;
#(
  parameter  int LINES          = 16,
  parameter  int WORDS_PER_LINE = 4,
  localparam int OFF_W          = $clog2(WORDS_PER_LINE),
  localparam int LINE_W         = WORD_W - BYTE_OFF_W - OFF_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              missReq,
  input  logic [LINE_W-1:0] missLine,
  input  logic              flush,
  input  logic              MemAck_FL0,
  input  logic              MemDataVal_FL0,
  output fillState_e        state,
  output logic [OFF_W-1:0]  beatCnt,
  output logic              beatWr,
  output logic              lineDone,
  output logic              dropLine,
  output logic [LINE_W-1:0] fillLine,
  output logic              MemReq_FL0,
  output logic [WORD_W-1:0] MemAddr_FL0
);

  fillState_e       stateQ, stateD;
  logic [OFF_W-1:0] cntQ, cntD;
  logic             dropQ, dropD;
  logic             lastBeat;

  assign lastBeat = (cntQ == OFF_W'(WORDS_PER_LINE - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ <= IDLE;
      cntQ   <= '0;
      dropQ  <= 1'b0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      dropQ  <= dropD;
    end
  end

  always_comb begin
    stateD     = stateQ;
    cntD       = cntQ;
    dropD      = dropQ;
    beatWr     = 1'b0;
    lineDone   = 1'b0;
    MemReq_FL0 = 1'b0;
    // Array writes are suppressed while reset is asserted so stray beats
    // during a reset cycle cannot touch the data array.
    if (!reset) begin
      case (stateQ)
        IDLE: begin
          if (missReq) begin
            stateD = REQ;
            dropD  = 1'b0;
          end
        end
        REQ: begin
          MemReq_FL0 = 1'b1;
          if (flush) dropD = 1'b1;
          // Beats seen before the ack belong to nobody and are ignored.
          if (MemAck_FL0) begin
            stateD = FILL;
            cntD   = '0;
          end
        end
        FILL: begin
          if (flush) dropD = 1'b1;
          if (MemDataVal_FL0) begin
            beatWr = 1'b1;
            cntD   = cntQ + 1'b1;
            if (lastBeat) begin
              lineDone = 1'b1;
              stateD   = DONE;
            end
          end
        end
        DONE: begin
          stateD = IDLE;
        end
        default: begin
          stateD = IDLE;
        end
      endcase
    end
  end

  // The line address is captured on the miss and held for the whole burst,
  // so a PC change while stalled cannot redirect the refill.
  dff #(.WIDTH(LINE_W)) lineReg (
    .clk   (clk),
    .reset (reset),
    .en    (missReq && (stateQ == IDLE)),
    .d     (missLine),
    .q     (fillLine)
  );

  assign state       = stateQ;
  assign beatCnt     = cntQ;
  assign dropLine    = dropQ;
  assign MemAddr_FL0 = {fillLine, {(OFF_W + BYTE_OFF_W){1'b0}}};

endmodule

// File: rtl/icache_fill.sv
// Direct-mapped instruction cache with line refill. Fetch lookups hit
// combinationally out of flop arrays; a miss stalls fetch, issues one
// line-aligned burst request and absorbs WORDS_PER_LINE beats before the
// lookup is retried on the held PC.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   PcReq_SY0       - fetch PC (bits [1:0] ignored)
//   Flush_SY0       - invalidate the whole cache (1-cycle pulse)
//   InstrFill_SY0   - instruction for PcReq_SY0, zero when not valid
//   InstrVal_SY0    - lookup hit this cycle
//   Stall_SY0       - miss or refill in progress; fetch holds PC
//   MemReq_FL0      - line request, held until MemAck_FL0
//   MemAddr_FL0     - line-aligned request address
//   MemAck_FL0      - request accepted
//   MemData_FL0     - fill beat data
//   MemDataVal_FL0  - fill beat valid (ascending word order, gaps allowed)
module icache_fill
  import mips_pkg::*;
#(
  parameter  int LINES          = 16,
  parameter  int WORDS_PER_LINE = 4,
  localparam int OFF_W          = $clog2(WORDS_PER_LINE),
  localparam int IDX_W          = $clog2(LINES),
  localparam int TAG_W          = WORD_W - BYTE_OFF_W - OFF_W - IDX_W,
  localparam int LINE_W         = WORD_W - BYTE_OFF_W - OFF_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] PcReq_SY0,
  input  logic              Flush_SY0,
  output logic [WORD_W-1:0] InstrFill_SY0,
  output logic              InstrVal_SY0,
  output logic              Stall_SY0,
  output logic              MemReq_FL0,
  output logic [WORD_W-1:0] MemAddr_FL0,
  input  logic              MemAck_FL0,
  input  logic [WORD_W-1:0] MemData_FL0,
  input  logic              MemDataVal_FL0
);

  logic [LINES-1:0]  validQ;
  logic [TAG_W-1:0]  tagArr  [LINES];
  logic [WORD_W-1:0] dataArr [LINES*WORDS_PER_LINE];

  logic [OFF_W-1:0]  reqWord;
  logic [IDX_W-1:0]  reqIdx;
  logic [TAG_W-1:0]  reqTag;
  logic [LINE_W-1:0] reqLine;

  fillState_e        state;
  logic [OFF_W-1:0]  beatCnt;
  logic              beatWr;
  logic              lineDone;
  logic              dropLine;
  logic [LINE_W-1:0] fillLine;
  logic [IDX_W-1:0]  fillIdx;
  logic [TAG_W-1:0]  fillTag;

  logic              lookupHit;
  logic              missReq;

  assign reqWord = OFF_W'(pcWord(PcReq_SY0, OFF_W));
  assign reqIdx  = IDX_W'(pcIdx(PcReq_SY0, OFF_W, IDX_W));
  assign reqTag  = TAG_W'(pcTag(PcReq_SY0, OFF_W, IDX_W));
  assign reqLine = PcReq_SY0[WORD_W-1:OFF_W+BYTE_OFF_W];

  assign fillIdx = fillLine[IDX_W-1:0];
  assign fillTag = fillLine[LINE_W-1:IDX_W];

  // Lookup only counts while IDLE; during DONE the freshly written line is
  // visible but the hit is deliberately deferred to the following cycle.
  assign lookupHit = (state == IDLE) && validQ[reqIdx] && (tagArr[reqIdx] == reqTag);
  assign missReq   = !reset && (state == IDLE) && !lookupHit;

  assign InstrVal_SY0  = !reset && lookupHit;
  assign InstrFill_SY0 = InstrVal_SY0 ? dataArr[{reqIdx, reqWord}] : '0;
  assign Stall_SY0     = !reset && !lookupHit;

  icache_fill_fsm #(
    .LINES          (LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) fsm (
    .clk            (clk),
    .reset          (reset),
    .missReq        (missReq),
    .missLine       (reqLine),
    .flush          (Flush_SY0),
    .MemAck_FL0     (MemAck_FL0),
    .MemDataVal_FL0 (MemDataVal_FL0),
    .state          (state),
    .beatCnt        (beatCnt),
    .beatWr         (beatWr),
    .lineDone       (lineDone),
    .dropLine       (dropLine),
    .fillLine       (fillLine),
    .MemReq_FL0     (MemReq_FL0),
    .MemAddr_FL0    (MemAddr_FL0)
  );

  // A flush always wins over the completing line, including when it lands
  // on the same cycle as the last beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      validQ <= '0;
    end else if (Flush_SY0) begin
      validQ <= '0;
    end else if (lineDone && !dropLine) begin
      validQ[fillIdx] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; validQ guards every read.
  always_ff @(posedge clk) begin
    if (beatWr) begin
      dataArr[{fillIdx, beatCnt}] <= MemData_FL0;
    end
    if (lineDone) begin
      tagArr[fillIdx] <= fillTag;
    end
  end

endmodule

// File: tb/tb_icache_fill.sv
// Bench for icache_fill (LINES=16, WORDS_PER_LINE=4): directed scenarios
// followed by randomized fetch/flush traffic, all checked against a
// line-level cache model.
module tb_icache_fill;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        flush;
  logic [31:0] instrFill;
  logic        instrVal;
  logic        stall;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memAck;
  logic [31:0] memData;
  logic        memDataVal;

  int checks = 0;
  int errors = 0;

  // Reference model: one entry per line.
  bit          refValid [16];
  logic [23:0] refTag   [16];
  logic [31:0] refData  [16][4];

  icache_fill #(.LINES(16), .WORDS_PER_LINE(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .PcReq_SY0      (pc),
    .Flush_SY0      (flush),
    .InstrFill_SY0  (instrFill),
    .InstrVal_SY0   (instrVal),
    .Stall_SY0      (stall),
    .MemReq_FL0     (memReq),
    .MemAddr_FL0    (memAddr),
    .MemAck_FL0     (memAck),
    .MemData_FL0    (memData),
    .MemDataVal_FL0 (memDataVal)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit predHit(input logic [31:0] a);
    return refValid[a[7:4]] && (refTag[a[7:4]] == a[31:8]);
  endfunction

  task automatic clearModel();
    for (int i = 0; i < 16; i++) refValid[i] = 1'b0;
  endtask

  // Reset, with a stray beat in the reset cycles; reset is released by the
  // next fetch.
  task automatic doReset();
    @(posedge clk); #1;
    reset = 1'b1; flush = 1'b0; memAck = 1'b0; memDataVal = 1'b1; memData = $urandom;
    @(posedge clk); #1;
    memDataVal = 1'b1; memData = $urandom;
    @(negedge clk);
    checkVal("rstMemReq", 32'(memReq), 32'd0);
    checkVal("rstStall", 32'(stall), 32'd0);
    checkVal("rstInstrVal", 32'(instrVal), 32'd0);
    checkVal("rstInstrFill", instrFill, 32'd0);
    checkVal("rstMemAddr", memAddr, 32'd0);
    clearModel();
  endtask

  // One fetch. On a predicted hit: single-cycle data check. On a miss: act
  // as the fill port with the given ack delay, beat gaps (gapArg<0 random
  // 0..2), stray beats in REQ and flush placement:
  //   -1 none, 0..3 with beat k, 10+k standalone pulse just before beat k,
  //   20 first REQ cycle, 30 DONE cycle.
  task automatic fetch(input logic [31:0] a, input logic [31:0] w[4], input int ackDly,
                       input int gapArg, input int strays, input int flushSel);
    int  idx, wrd, stallSeen, gaps, g;
    bit  hitE, flushed;
    idx = int'(a[7:4]);
    wrd = int'(a[3:2]);
    @(posedge clk); #1;
    reset = 1'b0; pc = a; flush = 1'b0; memAck = 1'b0; memDataVal = 1'b0;
    @(negedge clk);
    hitE = predHit(a);
    checkVal("lookupStall", 32'(stall), 32'(!hitE));
    checkVal("lookupMemReq", 32'(memReq), 32'd0);
    if (hitE) begin
      checkVal("hitVal", 32'(instrVal), 32'd1);
      checkVal("hitData", instrFill, refData[idx][wrd]);
      return;
    end
    checkVal("missVal", 32'(instrVal), 32'd0);
    checkVal("missFillZero", instrFill, 32'd0);
    stallSeen = int'(stall);
    gaps = 0;
    flushed = 1'b0;
    for (int c = 0; c <= ackDly; c++) begin
      @(posedge clk); #1;
      memAck = (c == ackDly);
      memDataVal = (c < strays);
      memData = $urandom;
      flush = (flushSel == 20) && (c == 0);
      if (flush) flushed = 1'b1;
      @(negedge clk);
      checkVal("reqMemReq", 32'(memReq), 32'd1);
      checkVal("reqMemAddr", memAddr, {a[31:4], 4'h0});
      stallSeen += int'(stall);
    end
    for (int k = 0; k < 4; k++) begin
      g = (gapArg >= 0) ? gapArg : int'($urandom_range(2, 0));
      if (flushSel == 10 + k) g++;
      for (int q = 0; q < g; q++) begin
        @(posedge clk); #1;
        memAck = 1'b0; memDataVal = 1'b0; memData = $urandom;
        flush = (flushSel == 10 + k) && (q == 0);
        if (flush) flushed = 1'b1;
        @(negedge clk);
        stallSeen += int'(stall);
        gaps++;
      end
      @(posedge clk); #1;
      memAck = 1'b0; memDataVal = 1'b1; memData = w[k];
      flush = (flushSel == k);
      if (flush) flushed = 1'b1;
      @(negedge clk);
      stallSeen += int'(stall);
    end
    @(posedge clk); #1;
    memDataVal = 1'b0;
    flush = (flushSel == 30);
    @(negedge clk);
    stallSeen += int'(stall);
    checkVal("doneMemReq", 32'(memReq), 32'd0);
    checkVal("stallCycles", 32'(stallSeen), 32'(1 + (ackDly + 1) + 4 + gaps + 1));
    if (!flushed) begin
      refValid[idx] = 1'b1;
      refTag[idx]   = a[31:8];
      for (int k = 0; k < 4; k++) refData[idx][k] = w[k];
    end
    if (flushed || flushSel == 30) clearModel();
  endtask

  // Flush while IDLE on a PC known to hit: this cycle still hits.
  task automatic flushIdle(input logic [31:0] a);
    @(posedge clk); #1;
    reset = 1'b0; pc = a; flush = 1'b1; memAck = 1'b0; memDataVal = 1'b0;
    @(negedge clk);
    checkVal("flushCycleHit", 32'(instrVal), 32'd1);
    checkVal("flushCycleData", instrFill, refData[a[7:4]][a[3:2]]);
    clearModel();
  endtask

  logic [31:0] w [4];
  logic [31:0] a;
  int          fs, ad;

  task automatic randWords();
    for (int k = 0; k < 4; k++) w[k] = $urandom;
  endtask

  initial begin
    reset = 1'b1; pc = '0; flush = 1'b0; memAck = 1'b0; memData = '0; memDataVal = 1'b0;
    clearModel();
    doReset();

    // Cold miss, then hits on the rest of the line.
    w = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    fetch(32'h0, w, 0, 0, 0, -1);
    for (int i = 0; i < 4; i++) fetch(32'(i * 4), w, 0, 0, 0, -1);

    // Conflict on index 0.
    w = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
    fetch(32'h100, w, 0, 0, 0, -1);
    fetch(32'h100, w, 0, 0, 0, -1);
    w = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    fetch(32'h0, w, 0, 0, 0, -1);
    fetch(32'h0, w, 0, 0, 0, -1);

    // Slow handshake with a stray beat in REQ.
    randWords();
    fetch(32'h30, w, 5, 2, 1, -1);
    for (int i = 0; i < 4; i++) fetch(32'h30 + 32'(i * 4), w, 0, 0, 0, -1);

    // Flush mid-fill, flush with the last beat, flush in DONE, flush in IDLE.
    randWords();
    fetch(32'h40, w, 0, 0, 0, 12);
    randWords();
    fetch(32'h40, w, 0, 0, 0, 3);
    randWords();
    fetch(32'h40, w, 1, 1, 0, -1);
    fetch(32'h44, w, 0, 0, 0, -1);
    randWords();
    fetch(32'h50, w, 0, 0, 0, 30);
    fetch(32'h40, w, 0, 0, 0, -1);
    fetch(32'h40, w, 0, 0, 0, -1);
    flushIdle(32'h48);
    fetch(32'h48, w, 0, 0, 0, -1);

    // Reset in the middle of a fill, then stray beats after release.
    randWords();
    fetch(32'h10, w, 0, 0, 0, -1);
    fetch(32'h10, w, 0, 0, 0, -1);
    @(posedge clk); #1;
    pc = 32'h20; flush = 1'b0; memAck = 1'b0; memDataVal = 1'b0;
    @(posedge clk); #1;
    memAck = 1'b1;
    @(posedge clk); #1;
    memAck = 1'b0; memDataVal = 1'b1; memData = $urandom;
    @(posedge clk); #1;
    memData = $urandom;
    doReset();
    randWords();
    fetch(32'h10, w, 2, 0, 2, -1);
    for (int i = 0; i < 4; i++) fetch(32'h10 + 32'(i * 4), w, 0, 0, 0, -1);
    fetch(32'h20, w, 0, 0, 0, -1);

    // Full sweep of all indices, then read every word back.
    for (int i = 0; i < 16; i++) begin
      randWords();
      fetch(32'(i * 16), w, int'($urandom_range(2, 0)), -1, 0, -1);
    end
    for (int i = 0; i < 64; i++) fetch(32'(i * 4), w, 0, 0, 0, -1);

    // Randomized traffic over a few tags per index.
    for (int it = 0; it < 150; it++) begin
      a = {22'($urandom_range(3, 0)), 4'($urandom), 4'($urandom), 2'b00};
      if (($urandom % 10) == 0 && predHit(a)) begin
        flushIdle(a);
      end else begin
        randWords();
        case ($urandom % 12)
          0:       fs = int'($urandom_range(3, 0));
          1:       fs = 10 + int'($urandom_range(3, 1));
          2:       fs = 20;
          3:       fs = 30;
          default: fs = -1;
        endcase
        ad = int'($urandom_range(3, 0));
        fetch(a, w, ad, -1, int'($urandom_range(ad + 1, 0)), fs);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
